// File: rtl/prog_loader_if.sv
// Byte-stream / instruction-memory bundle for prog_loader.
//
// Handshake: a byte moves on a rising clk edge where byte_valid and
// byte_ready are both high. The upstream side holds byte_data stable
// and keeps byte_valid high until that happens. byte_ready never
// depends on byte_valid.
// imem_we is a one-cycle write strobe. imem_addr and imem_wdata are
// valid while it is high. There is no back-pressure on writes.
// dbg_state carries the loader FSM encoding for observation.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rst;
  logic                  done;
  logic                  error;
  logic [2:0]            dbg_state;

  // Upstream byte source / memory-and-core observer side
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata,
    input  core_rst, done, error, dbg_state
  );

  // Loader side
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata,
    output core_rst, done, error, dbg_state
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader.
// The stream is a 16-bit little-endian word count N, then 4*N data bytes.
// The loader assembles little-endian 32-bit words and writes each one to
// instruction memory. It holds the core in reset until the whole image
// has landed.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, one
// trailing byte must equal the XOR of all data bytes.
module prog_loader #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  ld_if
);

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5,
    S_CHK   = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t                state_q;
  logic [15:0]           n_q;
  logic [15:0]           word_idx_q;
  logic [1:0]            byte_cnt_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  error_q;
  logic                  core_rst_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic                  accept;
  logic [15:0]           n_full;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  // ready_q holds the ready value for the current state. It is masked
  // while rst is high so nothing is accepted during the reset cycle.
  assign ld_if.byte_ready = ready_q & ~rst;
  assign accept           = ld_if.byte_valid & ld_if.byte_ready;
  // Full count as seen in LEN1, with the high byte arriving this cycle
  assign n_full           = {ld_if.byte_data, n_q[7:0]};
  // N <= DEPTH_WORDS is enforced before DATA, so this add cannot wrap
  assign last_word        = (word_idx_q + 16'd1) == n_q;
  assign word_addr        = BASE_ADDR + (ADDR_WIDTH'(word_idx_q) << 2);

  assign ld_if.imem_we    = we_q;
  assign ld_if.imem_addr  = addr_q;
  assign ld_if.imem_wdata = wdata_q;
  assign ld_if.core_rst   = core_rst_q;
  assign ld_if.done       = done_q;
  assign ld_if.error      = error_q;
  assign ld_if.dbg_state  = state_q;

  // Loader FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LEN0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      we_q       <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LEN0: begin
          if (accept) begin
            n_q[7:0] <= ld_if.byte_data;
            state_q  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept) begin
            n_q[15:8] <= ld_if.byte_data;
            if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              // An empty image still carries a checksum byte, expected 0x00
              state_q    <= S_CHK;
`else
              state_q    <= S_DONE;
              ready_q    <= 1'b0;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
`endif
            end else if ({1'b0, n_full} > DEPTH_L) begin
              state_q <= S_ERR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            // Bytes shift in from the top, so byte 0 ends up in [7:0]
            wdata_q    <= {ld_if.byte_data, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ ld_if.byte_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= word_addr;
            end
          end
        end
        S_WRITE: begin
          word_idx_q <= word_idx_q + 16'd1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_q    <= S_CHK;
            ready_q    <= 1'b1;
`else
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            core_rst_q <= 1'b0;
`endif
          end else begin
            state_q <= S_DATA;
            ready_q <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (ld_if.byte_data == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              core_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          state_q <= S_DONE;
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_ERR;
          ready_q <= 1'b0;
          error_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader (BASE_ADDR = 0x100, DEPTH_WORDS = 256).
// Bytes are driven through a valid/ready driver task. Expected imem writes
// are queued as {addr, data} when a stream is built. A monitor pops and
// compares them on every imem_we.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk;
  logic rst;

  prog_loader_if #(.ADDR_WIDTH(32)) bus ();

  prog_loader #(
    .ADDR_WIDTH  (32),
    .DEPTH_WORDS (256),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ld_if (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vecs;
  int          errs;
  logic [63:0] exp_q[$];
  logic [7:0]  stream_q[$];
  logic [31:0] words[256];
  logic [31:0] last_addr;
  logic [63:0] exp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_checks();
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_imem_we",    32'(bus.imem_we),    32'd0);
    check("rst_imem_addr",  bus.imem_addr,       BASE);
    check("rst_imem_wdata", bus.imem_wdata,      32'd0);
    check("rst_core_rst",   32'(bus.core_rst),   32'd1);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_error",      32'(bus.error),      32'd0);
  endtask

  // Reset is driven from the negedge. The reset cycle is checked, then each post-reset value.
  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_cycle_ready", 32'(bus.byte_ready), 32'd0);
    rst = 1'b0;
    #1;
    reset_checks();
    exp_q.delete();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Build the stream for words[0..n-1]. Queue the first n_exp writes.
  task automatic build(input int n, input int n_exp);
    logic [15:0] n16;
    logic [7:0]  x;
    n16 = 16'(n);
    x = 8'h00;
    stream_q.delete();
    stream_q.push_back(n16[7:0]);
    stream_q.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        stream_q.push_back(words[i][8*k +: 8]);
        x = x ^ words[i][8*k +: 8];
      end
    end
    if (CK == 1) stream_q.push_back(x);
    for (int i = 0; i < n_exp; i++)
      exp_q.push_back({BASE + 32'(4 * i), words[i]});
  endtask

  // Send the first count bytes of stream_q. Insert up to gap_max idle cycles before each byte.
  // Count the cycles where a presented byte was refused.
  task automatic send(input int count, input int gap_max, output int stalls);
    int gap;
    int tries;
    logic acc;
    stalls = 0;
    for (int i = 0; i < count; i++) begin
      gap = int'($urandom_range(gap_max, 0));
      if (gap > 0) begin
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = stream_q[i];
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        acc = bus.byte_ready;
        if (!acc) stalls++;
        tries++;
        @(negedge clk);
      end
      if (!acc) begin
        vecs++;
        errs++;
        $display("FAIL send_timeout: byte %0d never accepted, expected acceptance within 64 cycles", i);
        break;
      end
    end
    bus.byte_valid = 1'b0;
  endtask

  // Wait with a bound until done or error rises
  task automatic wait_end();
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.done || bus.error)) begin
      vecs++;
      errs++;
      $display("FAIL end_timeout: done=%0b error=%0b after 50 cycles, expected one set", bus.done, bus.error);
    end
    @(negedge clk);
  endtask

  task automatic end_checks(input logic exp_done);
    check("done",     32'(bus.done),     32'(exp_done));
    check("error",    32'(bus.error),    32'(!exp_done));
    check("core_rst", 32'(bus.core_rst), 32'(!exp_done));
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Hold a byte on the bus for a few cycles. It must never be taken.
  task automatic refuse_check();
    int seen;
    seen = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    repeat (4) begin
      if (bus.byte_ready) seen++;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    check("refused_after_end", 32'(seen), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      check("we_ready_low", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", bus.imem_addr,  exp_e[63:32]);
        check("write_data", bus.imem_wdata, exp_e[31:0]);
      end
      last_addr = bus.imem_addr;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int st;
    vecs = 0;
    errs = 0;
    last_addr = 32'h0;
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk);
    do_reset();

    // Basic image with valid held high: a single stall during the first WRITE
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_00B3;
    build(2, 2);
    send(stream_q.size(), 0, st);
    check("basic_stalls", 32'(st), 32'(1 + CK));
    wait_end();
    end_checks(1'b1);
    refuse_check();

    // Byte ordering with random idle gaps
    do_reset();
    words[0] = 32'h1234_5678;
    build(1, 1);
    send(stream_q.size(), 3, st);
    wait_end();
    end_checks(1'b1);

    // Basic again with random gaps: writes must be identical
    do_reset();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_00B3;
    build(2, 2);
    send(stream_q.size(), 3, st);
    wait_end();
    end_checks(1'b1);

    // Empty image
    do_reset();
    build(0, 0);
    send(stream_q.size(), 0, st);
    wait_end();
    end_checks(1'b1);

    // Oversize image: N = 0x0101. Only the length bytes are sent.
    do_reset();
    stream_q.delete();
    stream_q.push_back(8'h01);
    stream_q.push_back(8'h01);
    send(2, 0, st);
    wait_end();
    end_checks(1'b0);
    refuse_check();

    // Full depth: 256 words, last write lands at 0x100 + 0x3FC = 0x4FC
    do_reset();
    for (int i = 0; i < 256; i++)
      words[i] = {8'(i), 8'(~i), 8'hC3, 8'(i ^ 8'h5A)};
    build(256, 256);
    send(stream_q.size(), 0, st);
    check("full_stalls", 32'(st), 32'(255 + CK));
    wait_end();
    check("full_last_addr", last_addr, 32'h0000_04FC);
    end_checks(1'b1);

    // Reset mid-load after 2 of the 4 bytes of word 1
    do_reset();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_00B3;
    build(2, 1);
    send(8, 0, st);
    repeat (3) @(negedge clk);
    check("midload_word0_written", 32'(exp_q.size()), 32'd0);
    do_reset();
    build(2, 2);
    send(stream_q.size(), 0, st);
    wait_end();
    end_checks(1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum (A0 -> A1): words are still written, then error
    do_reset();
    words[0] = 32'h0000_0013;
    words[1] = 32'h0000_00B3;
    build(2, 2);
    check("csum_byte", 32'(stream_q[stream_q.size() - 1]), 32'h0000_00A0);
    stream_q[stream_q.size() - 1] = 8'hA1;
    send(stream_q.size(), 0, st);
    wait_end();
    end_checks(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
